// File: rtl/smpl_capture_if.sv
// smpl_capture_if: sample FIFO write port between the capture block and the FIFO.
// Signals: fifo_data (10b write data), fifo_wr (1-cycle write strobe), fifo_full (write-side full).
interface smpl_capture_if;
   logic [9:0] fifo_data;
   logic       fifo_wr;
   logic       fifo_full;

   modport master (
      output fifo_data,
      output fifo_wr,
      input  fifo_full
   );

   modport slave (
      input  fifo_data,
      input  fifo_wr,
      output fifo_full
   );
endinterface

// File: rtl/smpl_capture.sv
// smpl_capture: clkSmpl-side producer of the sample FIFO. Registers and decimates ADC codes,
// waits for a hysteresis edge trigger (or auto timeout) and writes N samples per acquisition.
// Ports: clkSmpl, n_reset (async low); adc_data[9:0]; arm in / captured out (4-phase handshake);
// trig_level[9:0], trig_edge, decim[7:0], auto_en (config); fifo (write port); overflow (sticky).
module smpl_capture #(
   parameter int unsigned N            = 320,
   parameter int unsigned HYST         = 8,
   parameter int unsigned AUTO_TIMEOUT = 1000000,
   parameter int unsigned SYNC         = 2
) (
   input  logic                clkSmpl,
   input  logic                n_reset,
   input  logic [9:0]          adc_data,
   input  logic                arm,
   output logic                captured,
   input  logic [9:0]          trig_level,
   input  logic                trig_edge,
   input  logic [7:0]          decim,
   input  logic                auto_en,
   output logic                overflow,
   smpl_capture_if.master      fifo
);

   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPT,
      ST_DONE
   } state_t;

   state_t          state;
   state_t          state_n;

   logic [SYNC-1:0] sync;
   logic            arm_s;
   logic [9:0]      s_in;
   logic [7:0]      dcnt;
   logic [TW-1:0]   tcnt;
   logic [CW-1:0]   cnt;
   logic            hyst;

   // configuration frozen for the duration of one acquisition
   logic [7:0]      dec_q;
   logic [9:0]      lvl_q;
   logic            edge_q;

   logic            strobe;
   logic [10:0]     lvl_x;
   logic [10:0]     hy_x;
   logic [10:0]     hi_x;
   logic [9:0]      lo;
   logic [9:0]      hi;
   logic            hyst_hit;
   logic            lvl_hit;
   logic            auto_hit;
   logic            fire;

   logic            arm_go;
   logic            slot;

   assign arm_s  = sync[SYNC-1];
   assign strobe = (dcnt == dec_q);

   // thresholds with saturation at the code range limits
   assign lvl_x = {1'b0, lvl_q};
   assign hy_x  = 11'(HYST);
   assign hi_x  = lvl_x + hy_x;
   assign lo    = (lvl_x >= hy_x) ? 10'(lvl_x - hy_x) : 10'd0;
   assign hi    = (hi_x > 11'd1023) ? 10'd1023 : hi_x[9:0];

   always_comb begin
      hyst_hit = 1'b0;
      lvl_hit  = 1'b0;
      unique case (1'b1)
         !edge_q: begin
            hyst_hit = (s_in <= lo);
            lvl_hit  = hyst && (s_in >= lvl_q);
         end
         edge_q: begin
            hyst_hit = (s_in >= hi);
            lvl_hit  = hyst && (s_in <= lvl_q);
         end
         default: begin
            hyst_hit = 1'b0;
            lvl_hit  = 1'b0;
         end
      endcase
   end

   assign auto_hit = auto_en && (tcnt == TW'(AUTO_TIMEOUT));
   // level and timeout on the same strobe collapse into one trigger
   assign fire     = strobe && (lvl_hit || auto_hit);

   // next state; slot marks a sample position (written or dropped on full)
   always_comb begin
      state_n = state;
      arm_go  = 1'b0;
      slot    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (arm_s && !captured) begin
               state_n = ST_ARMED;
               arm_go  = 1'b1;
            end
         end
         ST_ARMED: begin
            if (!arm_s) begin
               state_n = ST_IDLE;
            end else if (fire) begin
               slot    = 1'b1;
               state_n = (cnt == CW'(N - 1)) ? ST_DONE : ST_CAPT;
            end
         end
         ST_CAPT: begin
            if (!arm_s) begin
               state_n = ST_IDLE;
            end else if (strobe) begin
               slot = 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state_n = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (!arm_s) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         sync <= '0;
         s_in <= '0;
      end else begin
         sync <= {sync[SYNC-2:0], arm};
         s_in <= adc_data;
      end
   end

   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         dec_q  <= '0;
         lvl_q  <= '0;
         edge_q <= 1'b0;
      end else if (arm_go) begin
         dec_q  <= decim;
         lvl_q  <= trig_level;
         edge_q <= trig_edge;
      end
   end

   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         dcnt <= '0;
      end else if (arm_go || strobe) begin
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + 8'd1;
      end
   end

   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         tcnt <= '0;
      end else if (arm_go) begin
         tcnt <= '0;
      end else if (state == ST_ARMED && tcnt != TW'(AUTO_TIMEOUT)) begin
         tcnt <= tcnt + TW'(1);
      end
   end

   // hyst starts clear so a level already past threshold cannot fire
   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         hyst <= 1'b0;
      end else if (arm_go) begin
         hyst <= 1'b0;
      end else if (state == ST_ARMED && strobe && hyst_hit) begin
         hyst <= 1'b1;
      end
   end

   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         cnt <= '0;
      end else if (arm_go) begin
         cnt <= '0;
      end else if (slot) begin
         cnt <= cnt + CW'(1);
      end
   end

   // a sample dropped on full still occupies its slot in the record
   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         fifo.fifo_wr   <= 1'b0;
         fifo.fifo_data <= '0;
         overflow       <= 1'b0;
      end else begin
         fifo.fifo_wr <= slot && !fifo.fifo_full;
         if (slot && !fifo.fifo_full) begin
            fifo.fifo_data <= s_in;
         end
         if (arm_go) begin
            overflow <= 1'b0;
         end else if (slot && fifo.fifo_full) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clkSmpl or negedge n_reset) begin
      if (!n_reset) begin
         captured <= 1'b0;
      end else begin
         captured <= (state_n == ST_DONE);
      end
   end

endmodule

// File: tb/tb_smpl_capture.sv
// tb_smpl_capture: randomized and directed stimulus for smpl_capture, checked every cycle
// against a behavioural acquisition model plus literal expectations for the key scenarios.
module tb_smpl_capture;
   localparam int N    = 320;
   localparam int HYST = 8;
   localparam int TO   = 100;
   localparam int SYNC = 2;

   logic       clkSmpl = 1'b0;
   logic       n_reset = 1'b0;
   logic [9:0] adc_data = '0;
   logic       arm = 1'b0;
   logic       captured;
   logic [9:0] trig_level = '0;
   logic       trig_edge = 1'b0;
   logic [7:0] decim = '0;
   logic       auto_en = 1'b0;
   logic       overflow;

   smpl_capture_if fif ();

   smpl_capture #(
      .N(N), .HYST(HYST), .AUTO_TIMEOUT(TO), .SYNC(SYNC)
   ) dut (
      .clkSmpl    (clkSmpl),
      .n_reset    (n_reset),
      .adc_data   (adc_data),
      .arm        (arm),
      .captured   (captured),
      .trig_level (trig_level),
      .trig_edge  (trig_edge),
      .decim      (decim),
      .auto_en    (auto_en),
      .overflow   (overflow),
      .fifo       (fif.master)
   );

   always #5 clkSmpl = ~clkSmpl;

   int errors = 0;
   int checks = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // behavioural model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 done
   int m_ph, m_since, m_dec, m_lvl, m_edge, m_cnt, m_data, m_sin;
   int m_lo, m_hi;
   bit m_hyst, m_wr, m_cap, m_ovf, m_as, m_fire;
   bit m_sh [SYNC];

   function automatic void m_emit();
      if (fif.fifo_full) m_ovf = 1'b1;
      else begin
         m_wr   = 1'b1;
         m_data = m_sin;
      end
      m_cnt++;
      if (m_cnt == N) begin
         m_ph  = 3;
         m_cap = 1'b1;
      end
   endfunction

   initial forever begin
      @(posedge clkSmpl or negedge n_reset);
      if (!n_reset) begin
         m_ph = 0; m_since = 0; m_dec = 0; m_lvl = 0; m_edge = 0;
         m_cnt = 0; m_data = 0; m_sin = 0; m_hyst = 0;
         m_wr = 0; m_cap = 0; m_ovf = 0;
         for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
      end else begin
         m_as = m_sh[SYNC-1];
         m_wr = 1'b0;
         case (m_ph)
            0: if (m_as && !m_cap) begin
               m_ph = 1; m_since = 0; m_ovf = 0; m_hyst = 0; m_cnt = 0;
               m_dec = int'(decim); m_lvl = int'(trig_level);
               m_edge = int'(trig_edge);
            end
            1: begin
               m_since++;
               if (!m_as) m_ph = 0;
               else if (m_since % (m_dec + 1) == 0) begin
                  m_lo = (m_lvl - HYST < 0) ? 0 : m_lvl - HYST;
                  m_hi = (m_lvl + HYST > 1023) ? 1023 : m_lvl + HYST;
                  m_fire = (auto_en && m_since > TO) ||
                           (m_hyst && (m_edge != 0 ? m_sin <= m_lvl
                                                   : m_sin >= m_lvl));
                  if (m_edge != 0 ? m_sin >= m_hi : m_sin <= m_lo)
                     m_hyst = 1'b1;
                  if (m_fire) begin
                     m_ph = 2;
                     m_emit();
                  end
               end
            end
            2: begin
               m_since++;
               if (!m_as) m_ph = 0;
               else if (m_since % (m_dec + 1) == 0) m_emit();
            end
            default: if (!m_as) begin
               m_ph  = 0;
               m_cap = 1'b0;
            end
         endcase
         m_sin = int'(adc_data);
         for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
         m_sh[0] = arm;
      end
   end

   // cycle counter and write log
   int cyc = 0;
   int wq[$];
   int tq[$];

   initial forever begin
      @(posedge clkSmpl);
      cyc++;
   end

   initial forever begin
      @(negedge clkSmpl);
      if (n_reset) begin
         chk("fifo_wr", int'(fif.fifo_wr), int'(m_wr));
         chk("fifo_data", int'(fif.fifo_data), m_data);
         chk("captured", int'(captured), int'(m_cap));
         chk("overflow", int'(overflow), int'(m_ovf));
         if (fif.fifo_wr) begin
            wq.push_back(int'(fif.fifo_data));
            tq.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(negedge clkSmpl);
      #1;
   endtask

   task automatic clr();
      wq.delete();
      tq.delete();
   endtask

   task automatic disarm();
      arm = 1'b0;
      repeat (6) tick();
   endtask

   task automatic cfg(int lvl, bit e, int d, bit a);
      trig_level = 10'(lvl);
      trig_edge  = e;
      decim      = 8'(d);
      auto_en    = a;
   endtask

   int k, t0, hold, bad_g, bad_d, bad_f;
   bit fdone;

   initial begin
      fif.fifo_full = 1'b0;
      repeat (3) tick();
      chk("rst_wr", int'(fif.fifo_wr), 0);
      chk("rst_data", int'(fif.fifo_data), 0);
      chk("rst_captured", int'(captured), 0);
      chk("rst_overflow", int'(overflow), 0);
      n_reset = 1'b1;
      repeat (2) tick();

      // rising trigger on a ramp
      cfg(512, 1'b0, 0, 1'b0);
      clr();
      adc_data = 10'd400;
      arm = 1'b1;
      for (int i = 0; i < 1500 && !captured; i++) begin
         tick();
         if (adc_data != 10'h3ff) adc_data++;
      end
      chk("t1_captured", int'(captured), 1);
      chk("t1_writes", wq.size(), N);
      chk("t1_first", (wq.size() > 0) ? wq[0] : -1, 512);
      chk("t1_last", (wq.size() > 0) ? wq[wq.size()-1] : -1, 831);
      chk("t1_span", (tq.size() > 0) ? tq[tq.size()-1] - tq[0] : -1, N - 1);
      arm = 1'b0;
      k = 0;
      while (captured && k < 10) begin
         tick();
         k++;
      end
      chk("t1_release", k, SYNC + 1);
      repeat (4) tick();

      // falling trigger with hysteresis
      cfg(300, 1'b1, 0, 1'b0);
      clr();
      arm = 1'b1;
      for (int i = 0; i < 200; i++) begin
         adc_data = (i % 2 != 0) ? 10'd301 : 10'd298;
         tick();
      end
      chk("t2_no_trig", wq.size(), 0);
      adc_data = 10'd290;
      tick();
      for (int v = 291; v <= 320; v++) begin
         adc_data = 10'(v);
         tick();
      end
      for (int v = 319; v >= 250; v--) begin
         adc_data = 10'(v);
         tick();
      end
      for (int i = 0; i < 800 && !captured; i++) tick();
      chk("t2_first", (wq.size() > 0) ? wq[0] : -1, 300);
      chk("t2_writes", wq.size(), N);
      disarm();

      // decimation by 4 on a counting input
      cfg(100, 1'b0, 3, 1'b0);
      clr();
      adc_data = '0;
      arm = 1'b1;
      for (int i = 0; i < 3000 && !captured; i++) begin
         tick();
         adc_data++;
      end
      chk("t3_writes", wq.size(), N);
      bad_g = 0;
      bad_d = 0;
      for (int i = 1; i < wq.size(); i++) begin
         if (tq[i] - tq[i-1] != 4) bad_g++;
         if (((wq[i] - wq[i-1]) & 1023) != 4) bad_d++;
      end
      chk("t3_gap_bad", bad_g, 0);
      chk("t3_diff_bad", bad_d, 0);
      disarm();

      // auto trigger on a flat input
      cfg(512, 1'b0, 0, 1'b1);
      clr();
      adc_data = '0;
      t0 = cyc;
      arm = 1'b1;
      for (int i = 0; i < 600 && !captured; i++) tick();
      chk("t4_start", (tq.size() > 0) ? tq[0] - t0 : -1, SYNC + 1 + TO + 1);
      chk("t4_writes", wq.size(), N);
      disarm();
      auto_en = 1'b0;
      clr();
      arm = 1'b1;
      repeat (10000) tick();
      chk("t4_noauto", wq.size(), 0);
      disarm();

      // fifo full during writes 10..19
      cfg(512, 1'b0, 0, 1'b0);
      clr();
      adc_data = 10'd400;
      hold = 0;
      bad_f = 0;
      fdone = 1'b0;
      arm = 1'b1;
      for (int i = 0; i < 1500 && !captured; i++) begin
         tick();
         if (adc_data != 10'h3ff) adc_data++;
         if (hold > 0) begin
            if (fif.fifo_wr) bad_f++;
            hold--;
            if (hold == 0) fif.fifo_full = 1'b0;
         end else if (!fdone && wq.size() == 10) begin
            fif.fifo_full = 1'b1;
            hold = 10;
            fdone = 1'b1;
         end
      end
      chk("t5_full_wr", bad_f, 0);
      chk("t5_overflow", int'(overflow), 1);
      chk("t5_writes", wq.size(), N - 10);
      chk("t5_captured", int'(captured), 1);
      disarm();
      chk("t5_ovf_sticky", int'(overflow), 1);
      arm = 1'b1;
      repeat (4) tick();
      chk("t5_ovf_clear", int'(overflow), 0);
      disarm();

      // randomized acquisitions against the model
      for (int r = 0; r < 6; r++) begin
         cfg(int'($urandom_range(100, 900)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 1'b1);
         clr();
         arm = 1'b1;
         for (int i = 0; i < 2500 && !captured; i++) begin
            adc_data = 10'($urandom_range(0, 1023));
            fif.fifo_full = ($urandom_range(0, 15) == 0);
            tick();
         end
         fif.fifo_full = 1'b0;
         chk("rnd_captured", int'(captured), 1);
         disarm();
      end

      // abort after 50 writes
      cfg(512, 1'b0, 0, 1'b0);
      clr();
      adc_data = 10'd400;
      arm = 1'b1;
      for (int i = 0; i < 1000 && wq.size() < 50; i++) begin
         tick();
         adc_data++;
      end
      arm = 1'b0;
      repeat (20) begin
         tick();
         adc_data++;
      end
      chk("t6_abort_writes", wq.size(), 50 + SYNC);
      chk("t6_abort_captured", int'(captured), 0);

      // asynchronous reset in the middle of a capture
      clr();
      adc_data = 10'd400;
      arm = 1'b1;
      for (int i = 0; i < 1000 && wq.size() < 20; i++) begin
         tick();
         adc_data++;
      end
      n_reset = 1'b0;
      #1;
      chk("t6_rst_wr", int'(fif.fifo_wr), 0);
      chk("t6_rst_data", int'(fif.fifo_data), 0);
      chk("t6_rst_captured", int'(captured), 0);
      chk("t6_rst_overflow", int'(overflow), 0);
      arm = 1'b0;
      repeat (3) tick();
      n_reset = 1'b1;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
